quant_matrix_loader: RTL
========================

# quant_matrix_loader

Sequencer that uploads quantiser matrices into `intra_quant_matrix` and `non_intra_quant_matrix`. It accepts a command from the header parser (reset to defaults, load intra, load non-intra), then consumes 64 zigzag-ordered bytes over a valid/ready handshake. It drives the shared write port of both matrix blocks, and sits between the variable-length decoder's header path and the two matrix instances.

## Interface
- No parameters. Matrix size is 64 entries and entry width is 8 bits, both fixed.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-low reset.
- `clk_en` in 1: global clock enable. All state advances and handshakes complete only when it is high.
- `cmd_valid` in 1: command present.
- `cmd_sel` in 2: command code. 00 = reset both matrices to defaults, 01 = load intra, 10 = load non-intra, 11 = reserved.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready && clk_en`.
- `byte_valid` in 1: matrix byte present.
- `byte_dta` in 8: matrix value, in zigzag transmission order.
- `byte_ready` out 1: byte accepted when `byte_valid && byte_ready && clk_en`.
- `abort` in 1: abandon the current load (e.g. a sequence header error).
- `quant_wr_addr` out 6: zigzag index, shared by both matrices.
- `quant_wr_dta` out 8: write data, shared.
- `quant_wr_clk_en` out 1: write strobe qualifier, shared.
- `intra_wr_en` / `non_intra_wr_en` out 1 each: per-matrix write enable.
- `intra_rst_values` / `non_intra_rst_values` out 1 each: per-matrix revert-to-default request.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a command completes.
- `zero_err` out 1: sticky flag, set if a zero byte was written. Cleared on the next accepted command.

## Operation
- States: IDLE, RESET, LOAD, DONE, ABORT.
- **IDLE**
  - `cmd_ready`=1.
  - On an accepted command:
    - 00 → RESET.
    - 01 or 10 → LOAD. Latch the target; counter ← 0.
    - 11 → DONE with no writes, and `zero_err` unchanged.
- **RESET**
  - One cycle with `quant_wr_clk_en`=1 and both `*_rst_values`=1.
  - Then → DONE.
- **LOAD**
  - `byte_ready`=1.
  - Each accepted byte produces one write: `quant_wr_addr`=counter, `quant_wr_dta`=byte, `quant_wr_clk_en`=1, and the target `*_wr_en`=1.
  - The counter increments after each write.
  - The byte written at counter 63 ends the load → DONE. The matrix block clears its default flag on that write.
  - A byte of 0x00 is still written, and sets `zero_err`.
- **DONE**: `done`=1 for one cycle → IDLE.
- **ABORT**
  - Entered from LOAD when `abort`=1.
  - One cycle asserting the target's `*_rst_values` with `quant_wr_clk_en`=1, so a partial upload never becomes active.
  - Then → IDLE. No `done` pulse.
- `abort` in IDLE, RESET or DONE is ignored.
- In LOAD, if `abort` and an accepted byte occur in the same cycle, `abort` wins: the byte is consumed but not written.
- `cmd_valid` outside IDLE is not accepted; the source holds it.
- The non-target matrix never sees `wr_en` or `rst_values` during a load.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE, counter = 0, `zero_err` = 0.
  - `cmd_ready` = 1.
  - All other outputs = 0.
- Write outputs appear the cycle after the byte handshake and hold for exactly one `clk_en`-qualified cycle.
- `byte_ready` is a combinational function of the registered state (LOAD), not of `byte_valid`.
- Throughput is one byte per enabled cycle.
- A full load is command cycle + 64 byte cycles, and `done` appears 1 cycle after the last write.
- `clk_en`=0 freezes all state. Pulse outputs (`done`, write strobes) deassert while frozen and resume afterwards, so the matrix blocks see each write exactly once.
- Asynchronous reset mid-load returns to IDLE immediately; no reset pulse is issued to the matrices.

## Structure
- Shared package `mpeg2_quant_pkg` holds:
  - command codes `QCMD_RESET`, `QCMD_INTRA`, `QCMD_NON_INTRA`;
  - one-hot state encodings;
  - `QM_LAST_ADDR` = 6'h3f.
- Single module; no sub-module is warranted. The 6-bit counter and the FSM are inline.

## Test plan
- Cmd 01, then bytes 1..64 back-to-back → 64 writes to addrs 0..63 with `intra_wr_en` only; `done` 1 cycle after addr 63; `zero_err`=0.
- Cmd 10 with `byte_valid` toggling every other cycle and `clk_en` dropped for 3 cycles mid-load → 64 writes in order, no duplicates, `non_intra_wr_en` only.
- Cmd 01, 20 bytes, then `abort` → `intra_rst_values` pulse, no `done`, back to IDLE; `non_intra_*` stay 0.
- Cmd 00 → single cycle with both `*_rst_values`=1 and `quant_wr_clk_en`=1, then `done`.
- Cmd 10 with byte 0x00 at index 5 → write occurs, `zero_err`=1 after it; the next cmd acceptance clears it.
- `rst` asserted at byte 30 of a load → all outputs at reset values immediately; a new cmd 01 then completes normally.

Source files
------------

// File: rtl/mpeg2_quant_pkg.sv
// Shared definitions for the quantiser matrix upload path: command codes,
// one-hot sequencer states and matrix geometry.
package mpeg2_quant_pkg;

    localparam logic [1:0] QCMD_RESET     = 2'b00;
    localparam logic [1:0] QCMD_INTRA     = 2'b01;
    localparam logic [1:0] QCMD_NON_INTRA = 2'b10;

    localparam logic [5:0] QM_LAST_ADDR = 6'h3f;

    typedef enum logic [4:0] {
        QST_IDLE  = 5'b00001,
        QST_RESET = 5'b00010,
        QST_LOAD  = 5'b00100,
        QST_DONE  = 5'b01000,
        QST_ABORT = 5'b10000
    } qm_state_t;

endpackage

// File: rtl/quant_matrix_loader.sv
// Uploads 64 zigzag bytes into the intra or non-intra quantiser matrix, or reverts both to defaults.
// Latency: write strobe one cycle after each byte handshake; done one cycle after the last write.
// Backpressure: byte_ready only in LOAD, cmd_ready only in IDLE; clk_en low freezes everything.
module quant_matrix_loader
    import mpeg2_quant_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_sel,
    output logic       cmd_ready,
    input  logic       byte_valid,
    input  logic [7:0] byte_dta,
    output logic       byte_ready,
    input  logic       abort,
    output logic [5:0] quant_wr_addr,
    output logic [7:0] quant_wr_dta,
    output logic       quant_wr_clk_en,
    output logic       intra_wr_en,
    output logic       non_intra_wr_en,
    output logic       intra_rst_values,
    output logic       non_intra_rst_values,
    output logic       busy,
    output logic       done,
    output logic       zero_err
);

    qm_state_t  state;
    logic [5:0] cnt;
    logic       tgt_intra;
    logic       wr_q;
    logic       intra_wr_q;
    logic       non_intra_wr_q;
    logic       intra_rst_q;
    logic       non_intra_rst_q;
    logic       done_q;

    assign cmd_ready  = (state == QST_IDLE);
    assign byte_ready = (state == QST_LOAD);
    assign busy       = (state != QST_IDLE);

    // Pulse registers hold across a freeze; gating with clk_en hides them until the
    // enabled cycle, so the matrix blocks capture each strobe exactly once.
    assign quant_wr_clk_en      = wr_q & clk_en;
    assign intra_wr_en          = intra_wr_q & clk_en;
    assign non_intra_wr_en      = non_intra_wr_q & clk_en;
    assign intra_rst_values     = intra_rst_q & clk_en;
    assign non_intra_rst_values = non_intra_rst_q & clk_en;
    assign done                 = done_q & clk_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= QST_IDLE;
            cnt             <= 6'd0;
            tgt_intra       <= 1'b0;
            wr_q            <= 1'b0;
            intra_wr_q      <= 1'b0;
            non_intra_wr_q  <= 1'b0;
            intra_rst_q     <= 1'b0;
            non_intra_rst_q <= 1'b0;
            done_q          <= 1'b0;
            quant_wr_addr   <= 6'd0;
            quant_wr_dta    <= 8'd0;
            zero_err        <= 1'b0;
        end else if (clk_en) begin
            wr_q            <= 1'b0;
            intra_wr_q      <= 1'b0;
            non_intra_wr_q  <= 1'b0;
            intra_rst_q     <= 1'b0;
            non_intra_rst_q <= 1'b0;
            done_q          <= 1'b0;
            unique case (state)
                QST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_sel)
                            QCMD_RESET: begin
                                state           <= QST_RESET;
                                wr_q            <= 1'b1;
                                intra_rst_q     <= 1'b1;
                                non_intra_rst_q <= 1'b1;
                                zero_err        <= 1'b0;
                            end
                            QCMD_INTRA, QCMD_NON_INTRA: begin
                                state     <= QST_LOAD;
                                tgt_intra <= (cmd_sel == QCMD_INTRA);
                                cnt       <= 6'd0;
                                zero_err  <= 1'b0;
                            end
                            default: state <= QST_DONE;
                        endcase
                    end
                end
                QST_RESET: state <= QST_DONE;
                QST_LOAD: begin
                    // Abort beats a simultaneous byte: it is consumed but never written.
                    if (abort) begin
                        state           <= QST_ABORT;
                        wr_q            <= 1'b1;
                        intra_rst_q     <= tgt_intra;
                        non_intra_rst_q <= !tgt_intra;
                    end else if (byte_valid) begin
                        wr_q           <= 1'b1;
                        intra_wr_q     <= tgt_intra;
                        non_intra_wr_q <= !tgt_intra;
                        quant_wr_addr  <= cnt;
                        quant_wr_dta   <= byte_dta;
                        cnt            <= cnt + 6'd1;
                        if (byte_dta == 8'd0) begin
                            zero_err <= 1'b1;
                        end
                        if (cnt == QM_LAST_ADDR) begin
                            state <= QST_DONE;
                        end
                    end
                end
                QST_DONE: begin
                    done_q <= 1'b1;
                    state  <= QST_IDLE;
                end
                QST_ABORT: state <= QST_IDLE;
                default:   state <= QST_IDLE;
            endcase
        end
    end

endmodule
